// File: rtl/imm_encoder_if.sv
// Command and instruction handshake bundle for the RV32I immediate encoder.
// The master drives commands and consumes instructions; the slave is the encoder.
interface imm_encoder_if;
  // Command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_fmt;
  logic [6:0]  cmd_opcode;
  logic [2:0]  cmd_funct3;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [31:0] cmd_imm;

  // Instruction channel
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic        ins_last;
  logic        ins_err;

  modport master (
    output cmd_valid, cmd_fmt, cmd_opcode, cmd_funct3, cmd_rd, cmd_rs1,
           cmd_rs2, cmd_imm, ins_ready,
    input  cmd_ready, ins_valid, ins_data, ins_last, ins_err
  );

  modport slave (
    input  cmd_valid, cmd_fmt, cmd_opcode, cmd_funct3, cmd_rd, cmd_rs1,
           cmd_rs2, cmd_imm, ins_ready,
    output cmd_ready, ins_valid, ins_data, ins_last, ins_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Streaming RV32I instruction encoder. Scatters a flat immediate into the
// I/S/B/J/U instruction layouts, flags out-of-range immediates, and expands
// the LI pseudo-op into lui/addi. Output is a single registered word with a
// one-deep holding slot for the second LI word.
module imm_encoder (
  input  logic         clk,
  input  logic         rst,
  imm_encoder_if.slave bus
);

  // Format codes shared with the core's immediate extender
  localparam logic [2:0] FMT_I  = 3'b000;
  localparam logic [2:0] FMT_S  = 3'b001;
  localparam logic [2:0] FMT_B  = 3'b010;
  localparam logic [2:0] FMT_J  = 3'b011;
  localparam logic [2:0] FMT_U  = 3'b100;
  localparam logic [2:0] FMT_LI = 3'b101;

  localparam logic [6:0]  OP_LUI  = 7'b0110111;
  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [31:0] INS_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        valid_q, valid_d;
  logic [31:0] data_q,  data_d;
  logic        last_q,  last_d;
  logic        err_q,   err_d;
  logic [31:0] word2_q, word2_d;

  // Encoder results for the command currently on the bus
  logic [31:0] enc_word1;
  logic [31:0] enc_word2;
  logic        enc_two;
  logic        enc_err;

  logic        ready;
  logic        accept;
  logic        drain;

  // Range and LI helper terms
  logic [31:0] imm;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic [19:0] li_hi;
  logic [11:0] li_lo;

  assign imm    = bus.cmd_imm;
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);
  // lo is sign-extended by addi, so hi absorbs the borrow from imm[11]
  assign li_hi  = imm[31:12] + {19'd0, imm[11]};
  assign li_lo  = imm[11:0];

  // Field packing and range check for each command format
  always_comb begin
    enc_word1 = INS_NOP;
    enc_word2 = INS_NOP;
    enc_two   = 1'b0;
    enc_err   = 1'b0;
    unique case (bus.cmd_fmt)
      FMT_I: begin
        enc_word1 = {imm[11:0], bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd,
                     bus.cmd_opcode};
        enc_err   = ~fits12;
      end
      FMT_S: begin
        enc_word1 = {imm[11:5], bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3,
                     imm[4:0], bus.cmd_opcode};
        enc_err   = ~fits12;
      end
      FMT_B: begin
        enc_word1 = {imm[12], imm[10:5], bus.cmd_rs2, bus.cmd_rs1,
                     bus.cmd_funct3, imm[4:1], imm[11], bus.cmd_opcode};
        enc_err   = ~fits13 | imm[0];
      end
      FMT_J: begin
        enc_word1 = {imm[20], imm[10:1], imm[11], imm[19:12], bus.cmd_rd,
                     bus.cmd_opcode};
        enc_err   = ~fits21 | imm[0];
      end
      FMT_U: begin
        enc_word1 = {imm[31:12], bus.cmd_rd, bus.cmd_opcode};
        enc_err   = |imm[11:0];
      end
      FMT_LI: begin
        if (fits12) begin
          enc_word1 = {imm[11:0], 5'd0, 3'b000, bus.cmd_rd, OP_IMM};
        end else begin
          enc_word1 = {li_hi, bus.cmd_rd, OP_LUI};
          enc_word2 = {li_lo, bus.cmd_rd, 3'b000, bus.cmd_rd, OP_IMM};
          enc_two   = |li_lo;
        end
      end
      default: begin
        enc_word1 = INS_NOP;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Handshake, next-state and output-register update
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;
    word2_d = word2_q;

    unique case (state_q)
      IDLE:    ready = ~valid_q | bus.ins_ready;
      EMIT:    ready = bus.ins_ready;
      EMIT2:   ready = 1'b0;
      default: ready = 1'b0;
    endcase

    accept = bus.cmd_valid & ready;
    drain  = valid_q & bus.ins_ready;

    unique case (state_q)
      IDLE, EMIT: begin
        if (accept) begin
          valid_d = 1'b1;
          data_d  = enc_word1;
          last_d  = ~enc_two;
          err_d   = enc_err;
          word2_d = enc_word2;
          state_d = enc_two ? EMIT2 : EMIT;
        end else if (drain) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      EMIT2: begin
        if (drain) begin
          valid_d = 1'b1;
          data_d  = word2_q;
          last_d  = 1'b1;
          err_d   = 1'b0;
          state_d = EMIT;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      word2_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
      word2_q <= word2_d;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.ins_valid = valid_q;
  assign bus.ins_data  = data_q;
  assign bus.ins_last  = last_q;
  assign bus.ins_err   = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: single-word vector table plus hand-written
// sequences for LI expansion, back-to-back commands, backpressure and reset.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] data;
    logic        last;
    logic        err;
  } vec_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] fmt,
                              input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [31:0] data, input logic last,
                              input logic err);
    vec_t v;
    v.name = name; v.fmt = fmt; v.op = op; v.f3 = f3; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.data = data; v.last = last;
    v.err = err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.cmd_fmt    = v.fmt;
    bus.cmd_opcode = v.op;
    bus.cmd_funct3 = v.f3;
    bus.cmd_rd     = v.rd;
    bus.cmd_rs1    = v.rs1;
    bus.cmd_rs2    = v.rs2;
    bus.cmd_imm    = v.imm;
    bus.cmd_valid  = 1'b1;
  endtask

  // Called at a negedge with cmd_valid high; returns at the negedge
  // following the accepting posedge, with cmd_valid dropped.
  task automatic accept_cmd(input string name);
    int unsigned n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) chk({name, "_ready_timeout"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic chk_word(input string name, input logic [31:0] data,
                          input logic last, input logic err);
    chk({name, "_valid"}, 32'(bus.ins_valid), 32'd1);
    chk({name, "_data"},  bus.ins_data,       data);
    chk({name, "_last"},  32'(bus.ins_last),  32'(last));
    chk({name, "_err"},   32'(bus.ins_err),   32'(err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t li2, nxt;

    vecs[0]  = mk("i_neg1",    3'b000, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_8293, 1'b1, 1'b0);
    vecs[1]  = mk("b_fwd8",    3'b010, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_8463, 1'b1, 1'b0);
    vecs[2]  = mk("i_range",   3'b000, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0013, 1'b1, 1'b1);
    vecs[3]  = mk("b_odd",     3'b010, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h0000_0007, 32'h0020_8363, 1'b1, 1'b1);
    vecs[4]  = mk("s_sw16",    3'b001, 7'h23, 3'd2, 5'd0, 5'd2, 5'd3, 32'h0000_0010, 32'h0031_2823, 1'b1, 1'b0);
    vecs[5]  = mk("s_min",     3'b001, 7'h23, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0023, 1'b1, 1'b0);
    vecs[6]  = mk("b_back4",   3'b010, 7'h63, 3'd1, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_9EE3, 1'b1, 1'b0);
    vecs[7]  = mk("j_2048",    3'b011, 7'h6F, 3'd7, 5'd1, 5'd9, 5'd9, 32'h0000_0800, 32'h0010_00EF, 1'b1, 1'b0);
    vecs[8]  = mk("j_range",   3'b011, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h8000_00EF, 1'b1, 1'b1);
    vecs[9]  = mk("j_odd",     3'b011, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0003, 32'h0020_00EF, 1'b1, 1'b1);
    vecs[10] = mk("u_ok",      3'b100, 7'h37, 3'd5, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5137, 1'b1, 1'b0);
    vecs[11] = mk("u_lowbits", 3'b100, 7'h37, 3'd0, 5'd2, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_5137, 1'b1, 1'b1);
    vecs[12] = mk("fmt110",    3'b110, 7'h33, 3'd3, 5'd4, 5'd5, 5'd6, 32'h0000_0001, 32'h0000_0013, 1'b1, 1'b1);
    vecs[13] = mk("fmt111",    3'b111, 7'h6F, 3'd0, 5'd1, 5'd1, 5'd1, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1, 1'b1);
    vecs[14] = mk("li_lui",    3'b101, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_10B7, 1'b1, 1'b0);
    vecs[15] = mk("li_7ff",    3'b101, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_07FF, 32'h7FF0_0093, 1'b1, 1'b0);
    vecs[16] = mk("li_neg1",   3'b101, 7'h7F, 3'd7, 5'd3, 5'd9, 5'd9, 32'hFFFF_FFFF, 32'hFFF0_0193, 1'b1, 1'b0);
    vecs[17] = mk("li_top",    3'b101, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h8000_0000, 32'h8000_00B7, 1'b1, 1'b0);

    li2 = mk("li_two", 3'b101, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, 32'h1234_6537, 1'b0, 1'b0);

    bus.cmd_valid  = 1'b0;
    bus.cmd_fmt    = '0;
    bus.cmd_opcode = '0;
    bus.cmd_funct3 = '0;
    bus.cmd_rd     = '0;
    bus.cmd_rs1    = '0;
    bus.cmd_rs2    = '0;
    bus.cmd_imm    = '0;
    bus.ins_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst_data",  bus.ins_data,       32'd0);
    chk("rst_last",  32'(bus.ins_last),  32'd0);
    chk("rst_err",   32'(bus.ins_err),   32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);

    // Single-word table
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i]);
      accept_cmd(vecs[i].name);
      chk_word(vecs[i].name, vecs[i].data, vecs[i].last, vecs[i].err);
      @(negedge clk);
      chk({vecs[i].name, "_drained"}, 32'(bus.ins_valid), 32'd0);
    end

    // LI two words at full throughput
    drive(li2);
    accept_cmd("li_two");
    chk_word("li_two_w1", 32'h1234_6537, 1'b0, 1'b0);
    @(negedge clk);
    chk_word("li_two_w2", 32'hFFF5_0513, 1'b1, 1'b0);
    @(negedge clk);
    chk("li_two_drained", 32'(bus.ins_valid), 32'd0);

    // LI with hi wrapping to 0x80000, followed back-to-back by an I command
    drive(mk("li_wrap", 3'b101, 7'h00, 3'd0, 5'd2, 5'd0, 5'd0, 32'h7FFF_F801, 32'h0, 1'b0, 1'b0));
    accept_cmd("li_wrap");
    drive(vecs[0]);
    chk_word("li_wrap_w1", 32'h8000_0137, 1'b0, 1'b0);
    chk("li_wrap_ready_w1", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk_word("li_wrap_w2", 32'h8011_0113, 1'b1, 1'b0);
    chk("li_wrap_ready_w2", 32'(bus.cmd_ready), 32'd1);
    // Next command queued behind word 2 follows with no bubble
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk_word("b2b_i", 32'hFFF0_8293, 1'b1, 1'b0);

    // Back-to-back single-word commands, changing inputs after accept
    drive(vecs[1]);
    @(negedge clk);
    chk_word("b2b_b", 32'h0020_8463, 1'b1, 1'b0);
    drive(vecs[10]);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_imm   = 32'hDEAD_BEEF;
    chk_word("b2b_u", 32'h1234_5137, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_drained", 32'(bus.ins_valid), 32'd0);

    // Backpressure during LI: word 1 held, no new command, no loss
    bus.ins_ready = 1'b0;
    drive(li2);
    accept_cmd("bp");
    nxt = vecs[4];
    drive(nxt);
    for (int k = 0; k < 3; k++) begin
      chk_word("bp_hold", 32'h1234_6537, 1'b0, 1'b0);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.ins_ready = 1'b1;
    chk_word("bp_w1_final", 32'h1234_6537, 1'b0, 1'b0);
    @(negedge clk);
    chk_word("bp_w2", 32'hFFF5_0513, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_drained", 32'(bus.ins_valid), 32'd0);

    // Reset while word 2 is pending
    bus.ins_ready = 1'b0;
    drive(li2);
    accept_cmd("rst_mid");
    chk_word("rst_mid_w1", 32'h1234_6537, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus.ins_valid), 32'd0);
    rst = 1'b0;
    bus.ins_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst_mid_idle_ready", 32'(bus.cmd_ready), 32'd1);
    drive(vecs[2]);
    accept_cmd("post_rst");
    chk_word("post_rst", 32'h8000_0013, 1'b1, 1'b1);
    @(negedge clk);
    chk("post_rst_drained", 32'(bus.ins_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Streaming RV32I instruction encoder: takes a format-tagged command (register fields, opcode, funct3 and a flat 32-bit immediate) and scatters the immediate into the I/S/B/J/U bit positions of a 32-bit instruction word. It also expands the `LI` pseudo-op into one or two words (`lui`/`addi`). It feeds the instruction-memory loader and self-test sequencer. It is the inverse of the core's immediate extender, and reuses the same 3-bit format codes.

## Interface
Parameters:
- none

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — synchronous, active-high reset.
- `cmd_valid` in 1 — command present.
- `cmd_ready` out 1 — command accepted on `cmd_valid && cmd_ready`.
- `cmd_fmt` in 3 — command format:
  - 000 I; 001 S; 010 B; 011 J; 100 U; 101 LI.
  - 110 and 111 are illegal.
- `cmd_opcode` in 7 — opcode bits [6:0]; ignored for LI.
- `cmd_funct3` in 3 — funct3 bits [14:12]; ignored for J, U and LI.
- `cmd_rd` in 5 — destination register.
- `cmd_rs1` in 5 — source register 1.
- `cmd_rs2` in 5 — source register 2.
- `cmd_imm` in 32 — flat immediate, two's complement, byte offset for B/J.
- `ins_valid` out 1 — `ins_data` valid.
- `ins_ready` in 1 — consumer accepts on `ins_valid && ins_ready`.
- `ins_data` out 32 — encoded instruction.
- `ins_last` out 1 — final word of the current command.
- `ins_err` out 1 — immediate out of range or illegal format; the word is still emitted.

## Operation
Field packing (`op` = `cmd_opcode`, `f3` = `cmd_funct3`):
- I: {imm[11:0], rs1, f3, rd, op}.
- S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
- B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- U: {imm[31:12], rd, op}.

Range checks (set `ins_err`; fields are truncated as packed):
- I/S: imm[31:11] must be all-equal (signed 12-bit).
- B: imm[31:12] must be all-equal, and imm[0] must be 0.
- J: imm[31:20] must be all-equal, and imm[0] must be 0.
- U: imm[11:0] must be 0.
- Illegal format: emit 0x00000013 (nop) with `ins_err`=1 and `ins_last`=1.

LI expansion (never sets `ins_err`):
- If imm fits signed 12-bit: one word, `addi rd, x0, imm[11:0]`.
- Otherwise compute hi = imm[31:12] + imm[11] (mod 2^20) and lo = imm[11:0].
  - Word 1: `lui rd, hi` (opcode 0110111).
  - Word 2: `addi rd, rd, lo` (opcode 0010011, f3 000). Omitted when lo = 0.
- `ins_last` is set only on the final word.

State machine:
- IDLE:
  - `cmd_ready` = 1 when the output register is empty or being drained this cycle.
  - On accept: load word 1 into the output register; go to EMIT2 if a second LI word is needed, else go to EMIT.
- EMIT:
  - `cmd_ready` = 1 when `ins_ready` = 1.
  - On drain with no new command: go to IDLE.
  - Back-to-back accept allowed (stays in EMIT/EMIT2 per the new command).
- EMIT2:
  - `cmd_ready` = 0.
  - On drain of word 1: load the stored word 2 (`ins_last`=1), go to EMIT.

## Timing
- Reset (synchronous): state IDLE; `ins_valid`, `ins_data`, `ins_last`, `ins_err` = 0; `cmd_ready` = 1 the cycle after reset deasserts.
- Reset mid-operation discards any held or pending word. No word is output after the reset edge.
- Latency: command accepted at edge N gives `ins_valid`=1 from cycle N+1.
- Throughput: one word per cycle with `ins_ready` held high; LI with two words costs 2 cycles.
- While `ins_valid && !ins_ready`:
  - `ins_data`, `ins_last` and `ins_err` hold stable.
  - `ins_valid` does not drop.
- `cmd_*` inputs are sampled only on accept; later changes do not affect queued words.
- No combinational path from `cmd_*` to `ins_*`. `cmd_ready` may depend combinationally on `ins_ready`.

## Test plan
- **I-type:** fmt 000, op 0x13, f3 0, rd 5, rs1 1, imm 0xFFFFFFFF -> 0xFFF08293, err 0, last 1, one cycle after accept.
- **B-type:** fmt 010, op 0x63, f3 0, rs1 1, rs2 2, imm 8 -> 0x00208463.
- **Range error:** fmt 000, op 0x13, rd/rs1 0, imm 0x800 -> 0x80000013, err 1.
- **B odd offset:** imm 7 -> err 1.
- **LI two words:** rd 10, imm 0x12345FFF -> 0x12346537 (last 0), then 0xFFF50513 (last 1).
- **LI single-word cases:**
  - rd 1, imm 0x00001000 -> lui only, 0x000010B7, last 1.
  - rd 1, imm 0x7FF -> 0x7FF00093, last 1.
- **Backpressure and reset:**
  - Hold `ins_ready` low 3 cycles during LI -> word 1 stable, `cmd_ready` 0, no loss or duplication.
  - Assert `rst` while in EMIT2 -> `ins_valid` 0 next cycle; the next command encodes cleanly.
